// File: rtl/qam_symbol_serializer_if.sv
// Stream bundle around the symbol serializer: the word input stream and the
// symbol output stream. The slave modport is the serializer side; the master
// modport is the environment that feeds words and drains symbols.
interface qam_symbol_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SYM_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [1:0]            s_axis_mode;
  logic [SYM_WIDTH-1:0]  m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_mode, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_mode, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/qam_symbol_serializer.sv
// Splits data words into 1/2/4-bit constellation symbols, LSB first, with the
// symbol size chosen per word. A shift register holds the word being sent and
// a one-word holding register lets the next word wait so that back-to-back
// words leave without an idle cycle. Outputs are all registered.
module qam_symbol_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int SYM_WIDTH  = 4
) (
  input  logic aclk,
  input  logic resetn,
  qam_symbol_serializer_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_data_q, sr_data_d;
  logic [1:0]            sr_mode_q, sr_mode_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hr_data_q, hr_data_d;
  logic [1:0]            hr_mode_q, hr_mode_d;
  logic                  hr_valid_q, hr_valid_d;
  logic [SYM_WIDTH-1:0]  tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  sym_fire, last_fire, accept;

  // Bits per symbol for a mode; modes 2 and 3 are both 16-QAM.
  function automatic logic [2:0] bps_of(input logic [1:0] m);
    case (m)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Index of the final symbol of a word for a mode.
  function automatic logic [CW-1:0] last_idx(input logic [1:0] m);
    case (m)
      2'd0:    return CW'(DATA_WIDTH - 1);
      2'd1:    return CW'(DATA_WIDTH / 2 - 1);
      default: return CW'(DATA_WIDTH / 4 - 1);
    endcase
  endfunction

  // Low symbol of a word, zero-extended so unused MSBs read as zero.
  function automatic logic [SYM_WIDTH-1:0] sym_of(input logic [DATA_WIDTH-1:0] w,
                                                  input logic [1:0] m);
    case (m)
      2'd0:    return SYM_WIDTH'({3'b000, w[0]});
      2'd1:    return SYM_WIDTH'({2'b00, w[1:0]});
      default: return SYM_WIDTH'(w[3:0]);
    endcase
  endfunction

  // Next-state: shift on handshake, reload SR at word boundary from HR or input.
  always_comb begin
    state_d    = state_q;
    sr_data_d  = sr_data_q;
    sr_mode_d  = sr_mode_q;
    cnt_d      = cnt_q;
    hr_data_d  = hr_data_q;
    hr_mode_d  = hr_mode_q;
    hr_valid_d = hr_valid_q;
    sym_fire   = (state_q == SEND) && bus.m_axis_tready;
    last_fire  = sym_fire && tlast_q;
    accept     = bus.s_axis_tvalid && !hr_valid_q;

    if (sym_fire && !tlast_q) begin
      sr_data_d = sr_data_q >> bps_of(sr_mode_q);
      cnt_d     = cnt_q + 1'b1;
    end

    if ((state_q == EMPTY) || last_fire) begin
      // SR is free this cycle: the held word has priority over a new one.
      if (hr_valid_q) begin
        sr_data_d  = hr_data_q;
        sr_mode_d  = hr_mode_q;
        cnt_d      = '0;
        hr_valid_d = 1'b0;
        state_d    = SEND;
      end else if (accept) begin
        sr_data_d  = bus.s_axis_tdata;
        sr_mode_d  = bus.s_axis_mode;
        cnt_d      = '0;
        state_d    = SEND;
      end else begin
        cnt_d      = '0;
        state_d    = EMPTY;
      end
    end else if (accept) begin
      hr_data_d  = bus.s_axis_tdata;
      hr_mode_d  = bus.s_axis_mode;
      hr_valid_d = 1'b1;
    end

    tdata_d = (state_d == SEND) ? sym_of(sr_data_d, sr_mode_d) : '0;
    tlast_d = (state_d == SEND) && (cnt_d == last_idx(sr_mode_d));
  end

  // State and registered outputs; reset discards both the active and held word.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= EMPTY;
      sr_data_q  <= '0;
      sr_mode_q  <= '0;
      cnt_q      <= '0;
      hr_data_q  <= '0;
      hr_mode_q  <= '0;
      hr_valid_q <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_data_q  <= sr_data_d;
      sr_mode_q  <= sr_mode_d;
      cnt_q      <= cnt_d;
      hr_data_q  <= hr_data_d;
      hr_mode_q  <= hr_mode_d;
      hr_valid_q <= hr_valid_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
    end
  end

  assign bus.m_axis_tvalid = (state_q == SEND);
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.s_axis_tready = !hr_valid_q;

endmodule

// File: tb/tb_qam_symbol_serializer.sv
// Bench for qam_symbol_serializer: directed words from the datasheet examples,
// output stalls, mid-word reset and a randomized run, all checked against a
// queue-based model of the symbol stream and of word occupancy.
module tb_qam_symbol_serializer;

  logic aclk;
  logic resetn;

  qam_symbol_serializer_if #(.DATA_WIDTH(32), .SYM_WIDTH(4)) bus ();

  qam_symbol_serializer #(.DATA_WIDTH(32), .SYM_WIDTH(4)) dut (
    .aclk   (aclk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [3:0] d;
    logic       l;
  } sym_t;

  sym_t       exp_q[$];
  logic [3:0] got[$];
  int         occ;
  int         checks;
  int         errors;
  logic       acc_flag;
  logic       rand_rdy;
  logic       toggle_rdy;
  logic       prev_stall;
  logic [3:0] prev_tdata;
  logic       prev_tlast;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: a word of mode m expands to 32/bps symbols, symbol k = bits k*bps..
  task automatic model_push(input logic [31:0] w, input logic [1:0] m);
    int   b;
    int   n;
    sym_t e;
    b = (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
    n = 32 / b;
    for (int k = 0; k < n; k++) begin
      e.d = 4'((w >> (k * b)) & ((32'd1 << b) - 32'd1));
      e.l = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    sym_t e;
    logic fire;
    logic acc;
    @(negedge aclk);
    chk("s_tready", 32'(bus.s_axis_tready), 32'(occ < 2));
    chk("m_tvalid", 32'(bus.m_axis_tvalid), 32'(occ > 0));
    if (prev_stall) begin
      chk("stall_tdata", 32'(bus.m_axis_tdata), 32'(prev_tdata));
      chk("stall_tlast", 32'(bus.m_axis_tlast), 32'(prev_tlast));
    end
    fire = bus.m_axis_tvalid && bus.m_axis_tready;
    acc  = bus.s_axis_tvalid && bus.s_axis_tready;
    if (fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL extra_symbol: observed %0h expected none", bus.m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("tdata", 32'(bus.m_axis_tdata), 32'(e.d));
        chk("tlast", 32'(bus.m_axis_tlast), 32'(e.l));
        if (e.l) occ--;
      end
      got.push_back(bus.m_axis_tdata);
    end
    if (acc) begin
      model_push(bus.s_axis_tdata, bus.s_axis_mode);
      occ++;
    end
    acc_flag   = acc;
    prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
    prev_tdata = bus.m_axis_tdata;
    prev_tlast = bus.m_axis_tlast;
    @(posedge aclk);
    #1;
    if (rand_rdy) bus.m_axis_tready = ($urandom_range(0, 3) != 0);
    else if (toggle_rdy) bus.m_axis_tready = !bus.m_axis_tready;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [1:0] m);
    logic done;
    done = 1'b0;
    bus.s_axis_tdata  = w;
    bus.s_axis_mode   = m;
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      done = acc_flag;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed no accept expected accept of %0h", w);
    end
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && (occ != 0 || exp_q.size() != 0); i++) tick();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    occ               = 0;
    rand_rdy          = 1'b0;
    toggle_rdy        = 1'b0;
    prev_stall        = 1'b0;
    prev_tdata        = '0;
    prev_tlast        = 1'b0;
    acc_flag          = 1'b0;
    resetn            = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_mode   = 2'd0;
    bus.m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("rst_tdata",  32'(bus.m_axis_tdata),  32'd0);
    chk("rst_tlast",  32'(bus.m_axis_tlast),  32'd0);
    chk("rst_tready", 32'(bus.s_axis_tready), 32'd1);
    resetn = 1'b1;

    // 16-QAM word: symbols 1..8
    got.delete();
    push_word(32'h87654321, 2'd2);
    drain();
    chk("t1_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("t1_sym", 32'(got[i]), 32'(i + 1));

    // QPSK word: 3,2,1,0 then zeros, 16 symbols
    got.delete();
    push_word(32'h0000001B, 2'd1);
    drain();
    chk("t2_count", 32'(got.size()), 32'd16);
    if (got.size() == 16) begin
      chk("t2_s0", 32'(got[0]), 32'd3);
      chk("t2_s1", 32'(got[1]), 32'd2);
      chk("t2_s2", 32'(got[2]), 32'd1);
      chk("t2_s3", 32'(got[3]), 32'd0);
      chk("t2_s15", 32'(got[15]), 32'd0);
    end

    // BPSK word: 1,0,1 then zeros, 32 symbols
    got.delete();
    push_word(32'h00000005, 2'd0);
    drain();
    chk("t3_count", 32'(got.size()), 32'd32);
    if (got.size() == 32) begin
      chk("t3_s0", 32'(got[0]), 32'd1);
      chk("t3_s1", 32'(got[1]), 32'd0);
      chk("t3_s2", 32'(got[2]), 32'd1);
      chk("t3_s31", 32'(got[31]), 32'd0);
    end

    // Back-to-back 16-QAM then QPSK with tvalid held
    got.delete();
    push_word(32'h87654321, 2'd2);
    push_word(32'hFFFFFFFF, 2'd1);
    drain();
    chk("t4_count", 32'(got.size()), 32'd24);
    for (int i = 8; i < 24 && i < got.size(); i++) chk("t4_sym", 32'(got[i]), 32'd3);

    // Output stalls every other cycle, three words queued behind each other
    got.delete();
    toggle_rdy = 1'b1;
    push_word(32'hA5A5A5A5, 2'd2);
    push_word(32'hA5A5A5A5, 2'd2);
    push_word(32'hA5A5A5A5, 2'd3);
    drain();
    toggle_rdy        = 1'b0;
    bus.m_axis_tready = 1'b1;
    chk("t5_count", 32'(got.size()), 32'd24);
    for (int i = 0; i < 24 && i < got.size(); i++)
      chk("t5_sym", 32'(got[i]), (i % 2 == 0) ? 32'h5 : 32'hA);

    // Reset after the third symbol of a word
    got.delete();
    push_word(32'h87654321, 2'd2);
    for (int i = 0; i < 50 && got.size() < 3; i++) tick();
    chk("t6_pre", 32'(got.size()), 32'd3);
    resetn = 1'b0;
    #1;
    chk("t6_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
    chk("t6_tdata",  32'(bus.m_axis_tdata),  32'd0);
    chk("t6_tlast",  32'(bus.m_axis_tlast),  32'd0);
    chk("t6_tready", 32'(bus.s_axis_tready), 32'd1);
    exp_q.delete();
    occ        = 0;
    prev_stall = 1'b0;
    repeat (2) @(posedge aclk);
    #3;
    resetn = 1'b1;
    got.delete();
    push_word(32'h87654321, 2'd2);
    drain();
    chk("t6_count", 32'(got.size()), 32'd8);
    if (got.size() > 0) chk("t6_first", 32'(got[0]), 32'd1);

    // Randomized words, modes, input gaps and output backpressure
    rand_rdy = 1'b1;
    for (int w = 0; w < 40; w++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) tick();
      push_word($urandom, 2'($urandom_range(0, 3)));
    end
    drain();
    rand_rdy          = 1'b0;
    bus.m_axis_tready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
